alu: RTL and testbench
======================

# alu

32-bit MIPS-style arithmetic/logic unit for the datapath execute stage. It takes two register-file operands and a 4-bit ALU control code, and registers the result on the clock edge. It also produces a zero flag for branch comparison and a signed-overflow flag for add/sub exception logic.

## Interface
- `WIDTH`, 32, operand and result width
- `clk` input 1: rising-edge clock
- `rst_n` input 1: synchronous, active-low reset; one clock; reset is synchronous and active-low
- `read1` input WIDTH: operand A (rs)
- `read2` input WIDTH: operand B (rt/immediate)
- `operation` input 4: ALU control code
- `result` output WIDTH: registered operation result
- `zero` output 1: registered, 1 when `result` == 0
- `overflow` output 1: registered, signed overflow of ADD/SUB

## Operation
- 4'b0000 AND: A & B
- 4'b0001 OR: A | B
- 4'b0010 ADD: A + B, modulo 2^WIDTH, carry discarded
- 4'b0110 SUB: A − B, modulo 2^WIDTH (two's complement)
- 4'b0111 SLT: result = 1 if $signed(A) < $signed(B), else 0; zero-extended. Computed from the subtraction sign XOR its overflow, so it is correct at extremes, e.g. A=0x80000000, B=1 → 1.
- 4'b1100 NOR: ~(A | B)
- Any other code: result = 0, overflow = 0.
- overflow rules:
  - ADD: set when the operand signs are equal and the sum sign differs.
  - SUB: set when the operand signs differ and the difference sign differs from A.
  - All other ops: 0.
- zero is derived from the next-result value and registered alongside it, so it always matches `result`.
- Purely combinational datapath, with no internal state besides the output registers.

## Timing
- All outputs update only on rising `clk`.
- Latency is 1 cycle: inputs sampled at edge N appear on outputs after edge N.
- Inputs may change every cycle, giving a throughput of one operation per cycle with no handshake.
- Reset: when `rst_n`=0 at a rising edge, result=0, zero=1, overflow=0. Reset overrides any operation sampled in the same cycle.
- Deassert: the first computed result appears one edge after the edge where `rst_n` is sampled 1.
- Before the first clock edge, outputs are X; benches must reset first.

## Structure
- Package `alu_pkg`:
  - opcode localparams: ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_SLT=4'b0111, ALU_NOR=4'b1100
  - an `alu_op_t` 4-bit typedef
- One sub-module, `alu_addsub`:
  - combinational adder with a subtract control (B inverted plus carry-in)
  - outputs: sum, carry, signed-overflow
- The top-level case statement selects among the logic ops, `alu_addsub`, and SLT, then registers the result.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with A=5, B=7, ADD → result=0, zero=1, overflow=0.
- Logic ops with A=1, B=3, each applied for one cycle, result checked one edge later:
  - AND → 1
  - OR → 3
  - NOR → 0xFFFFFFFC
  - zero=0 in all three cases.
- Arithmetic with A=1, B=3:
  - ADD → 4
  - SUB → 0xFFFFFFFE
  - SLT → 1
  - SUB with A=3, B=3 → 0 with zero=1.
- Overflow cases:
  - ADD 0x7FFFFFFF + 1 → 0x80000000, overflow=1
  - SUB 0x80000000 − 1 → 0x7FFFFFFF, overflow=1
  - SLT 0x80000000 vs 1 → 1
- Unused code 4'b1111 → result=0, zero=1.
- Back-to-back: change the op every cycle (AND, OR, ADD, SUB, SLT, NOR) → each result appears exactly one cycle later. Then assert rst_n=0 mid-stream → outputs clear at the next edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU control encodings and helpers for the execute-stage ALU.
package alu_pkg;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ALU_AND = 4'b0000;
  localparam alu_op_t ALU_OR  = 4'b0001;
  localparam alu_op_t ALU_ADD = 4'b0010;
  localparam alu_op_t ALU_SUB = 4'b0110;
  localparam alu_op_t ALU_SLT = 4'b0111;
  localparam alu_op_t ALU_NOR = 4'b1100;

  // Operations that route B through the inverting path of the adder.
  function automatic logic needs_subtract(input alu_op_t op);
    return (op == ALU_SUB) || (op == ALU_SLT);
  endfunction

endpackage

// File: rtl/alu_addsub.sv
// Combinational adder/subtractor: subtract is A + ~B + 1, with carry and signed overflow.
module alu_addsub #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   full;

  always_comb begin
    b_eff = sub ? ~b : b;
    full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    sum   = full[WIDTH-1:0];
    carry = full[WIDTH];
    // Same-sign inputs to the adder producing a different-sign sum covers both ADD and SUB.
    overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/alu.sv
// MIPS-style 32-bit ALU with registered result, zero and signed-overflow flags.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] read1,
  input  logic [WIDTH-1:0] read2,
  input  logic [3:0]       operation,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);

  alu_op_t          op;
  logic [WIDTH-1:0] as_sum;
  logic             as_carry_unused;
  logic             as_ovf;
  logic [WIDTH-1:0] next_result;
  logic             next_ovf;

  assign op = alu_op_t'(operation);

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a        (read1),
    .b        (read2),
    .sub      (needs_subtract(op)),
    .sum      (as_sum),
    .carry    (as_carry_unused),
    .overflow (as_ovf)
  );

  always_comb begin
    next_result = '0;
    next_ovf    = 1'b0;
    case (op)
      ALU_AND: next_result = read1 & read2;
      ALU_OR:  next_result = read1 | read2;
      ALU_NOR: next_result = ~(read1 | read2);
      ALU_ADD, ALU_SUB: begin
        next_result = as_sum;
        next_ovf    = as_ovf;
      end
      // Sign of A-B corrected by overflow gives the true signed comparison.
      ALU_SLT: next_result = {{(WIDTH-1){1'b0}}, as_sum[WIDTH-1] ^ as_ovf};
      default: begin
        next_result = '0;
        next_ovf    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result   <= '0;
      zero     <= 1'b1;
      overflow <= 1'b0;
    end else begin
      result   <= next_result;
      zero     <= (next_result == '0);
      overflow <= next_ovf;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu: reset, logic, arithmetic, overflow, unused codes, streaming.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] read1;
  logic [31:0] read2;
  logic [3:0]  operation;
  logic [31:0] result;
  logic        zero;
  logic        overflow;

  int checks;
  int fails;

  alu #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .read1     (read1),
    .read2     (read2),
    .operation (operation),
    .result    (result),
    .zero      (zero),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; read1 = 32'd5; read2 = 32'd7; operation = 4'b0010;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (result !== 32'd0) begin fails++; $display("FAIL reset_result got=%h exp=%h", result, 32'd0); end
    checks++;
    if (zero !== 1'b1) begin fails++; $display("FAIL reset_zero got=%b exp=1", zero); end
    checks++;
    if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    rst_n = 1'b1;
  endtask

  task automatic test_logic();
    logic [3:0]  ops [3] = '{4'b0000, 4'b0001, 4'b1100};
    logic [31:0] exps[3] = '{32'h1, 32'h3, 32'hFFFF_FFFC};
    for (int i = 0; i < 3; i++) begin
      read1 = 32'd1; read2 = 32'd3; operation = ops[i];
      @(posedge clk); #1;
      checks++;
      if (result !== exps[i]) begin fails++; $display("FAIL logic_result op=%b got=%h exp=%h", ops[i], result, exps[i]); end
      checks++;
      if (zero !== 1'b0) begin fails++; $display("FAIL logic_zero op=%b got=%b exp=0", ops[i], zero); end
      checks++;
      if (overflow !== 1'b0) begin fails++; $display("FAIL logic_overflow op=%b got=%b exp=0", ops[i], overflow); end
    end
  endtask

  task automatic test_arith();
    logic [3:0]  ops [4] = '{4'b0010, 4'b0110, 4'b0111, 4'b0110};
    logic [31:0] as  [4] = '{32'd1, 32'd1, 32'd1, 32'd3};
    logic [31:0] bs  [4] = '{32'd3, 32'd3, 32'd3, 32'd3};
    logic [31:0] exps[4] = '{32'd4, 32'hFFFF_FFFE, 32'd1, 32'd0};
    logic        zs  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      read1 = as[i]; read2 = bs[i]; operation = ops[i];
      @(posedge clk); #1;
      checks++;
      if (result !== exps[i]) begin fails++; $display("FAIL arith_result idx=%0d got=%h exp=%h", i, result, exps[i]); end
      checks++;
      if (zero !== zs[i]) begin fails++; $display("FAIL arith_zero idx=%0d got=%b exp=%b", i, zero, zs[i]); end
      checks++;
      if (overflow !== 1'b0) begin fails++; $display("FAIL arith_overflow idx=%0d got=%b exp=0", i, overflow); end
    end
  endtask

  task automatic test_overflow();
    logic [3:0]  ops [3] = '{4'b0010, 4'b0110, 4'b0111};
    logic [31:0] as  [3] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [3] = '{32'd1, 32'd1, 32'd1};
    logic [31:0] exps[3] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'd1};
    logic        ovs [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      read1 = as[i]; read2 = bs[i]; operation = ops[i];
      @(posedge clk); #1;
      checks++;
      if (result !== exps[i]) begin fails++; $display("FAIL ovf_result idx=%0d got=%h exp=%h", i, result, exps[i]); end
      checks++;
      if (overflow !== ovs[i]) begin fails++; $display("FAIL ovf_flag idx=%0d got=%b exp=%b", i, overflow, ovs[i]); end
      checks++;
      if (zero !== 1'b0) begin fails++; $display("FAIL ovf_zero idx=%0d got=%b exp=0", i, zero); end
    end
  endtask

  task automatic test_unused();
    logic [3:0] ops[2] = '{4'b1111, 4'b0011};
    for (int i = 0; i < 2; i++) begin
      read1 = 32'h7FFF_FFFF; read2 = 32'd1; operation = ops[i];
      @(posedge clk); #1;
      checks++;
      if (result !== 32'd0) begin fails++; $display("FAIL unused_result op=%b got=%h exp=0", ops[i], result); end
      checks++;
      if (zero !== 1'b1) begin fails++; $display("FAIL unused_zero op=%b got=%b exp=1", ops[i], zero); end
      checks++;
      if (overflow !== 1'b0) begin fails++; $display("FAIL unused_overflow op=%b got=%b exp=0", ops[i], overflow); end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
    logic [31:0] exps[6] = '{32'h8, 32'hE, 32'h16, 32'h2, 32'h0, 32'hFFFF_FFF1};
    logic [31:0] prev;
    prev = result;
    for (int i = 0; i < 6; i++) begin
      read1 = 32'hC; read2 = 32'hA; operation = ops[i];
      #1;
      checks++;
      if (result !== prev) begin fails++; $display("FAIL b2b_hold idx=%0d got=%h exp=%h", i, result, prev); end
      @(posedge clk); #1;
      checks++;
      if (result !== exps[i]) begin fails++; $display("FAIL b2b_result idx=%0d got=%h exp=%h", i, result, exps[i]); end
      checks++;
      if (zero !== (exps[i] == 32'd0)) begin fails++; $display("FAIL b2b_zero idx=%0d got=%b exp=%b", i, zero, exps[i] == 32'd0); end
      prev = exps[i];
    end
    rst_n = 1'b0; read1 = 32'h7FFF_FFFF; read2 = 32'd1; operation = 4'b0010;
    @(posedge clk); #1;
    checks++;
    if (result !== 32'd0) begin fails++; $display("FAIL midreset_result got=%h exp=0", result); end
    checks++;
    if (zero !== 1'b1) begin fails++; $display("FAIL midreset_zero got=%b exp=1", zero); end
    checks++;
    if (overflow !== 1'b0) begin fails++; $display("FAIL midreset_overflow got=%b exp=0", overflow); end
    rst_n = 1'b1; read1 = 32'd1; read2 = 32'd1; operation = 4'b0010;
    @(posedge clk); #1;
    checks++;
    if (result !== 32'd2) begin fails++; $display("FAIL postreset_result got=%h exp=%h", result, 32'd2); end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_logic();
    test_arith();
    test_overflow();
    test_unused();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
